// File: rtl/svm_window_result_gen_pkg.sv
// Shared definitions for the slide-window result generator.
//   state_t  : frame sequencer states (IDLE / RUN / DRAIN)
//   SW_W_DEF, NUM_SW_DEF, SCORE_W_DEF : default geometry
//   SUM_W    : width of the exact bias-adjusted score (one guard bit)
//   is_pos() : strict "greater than zero" test on a SUM_W-bit signed sum
package svm_window_result_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SW_W_DEF    = 11;
  localparam int NUM_SW_DEF  = 1200;
  localparam int SCORE_W_DEF = 32;
  localparam int SUM_W       = SCORE_W_DEF + 1;

  // Positive means sign bit clear and not exactly zero.
  function automatic logic is_pos(input logic [SUM_W-1:0] sum);
    return !sum[SUM_W-1] && (sum != '0);
  endfunction

endpackage

// File: rtl/svm_window_result_gen_pipe.sv
// svm_score_pipe: two-stage add/compare pipeline, one score per clock.
//   Stage 1: sum = sext(score) + sext(bias) (SCORE_W+1 bits, exact), tag, side, valid.
//   Stage 2: out_valid, out_pos = (sum > 0), out_tag (held while idle),
//            out_side (zero while idle).
// Ports:
//   clk, rst (sync, active-low)
//   in_valid, score, bias, in_tag, in_side  -> stage 1
//   out_valid, out_pos, out_tag, out_side   <- stage 2 registers
module svm_score_pipe
  import svm_window_result_gen_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int SW_W    = SW_W_DEF,
  parameter int SIDE_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] bias,
  input  logic [SW_W-1:0]    in_tag,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  output logic               out_pos,
  output logic [SW_W-1:0]    out_tag,
  output logic [SIDE_W-1:0]  out_side
);

  logic               s1_valid_reg;
  logic [SCORE_W:0]   s1_sum_reg;
  logic [SW_W-1:0]    s1_tag_reg;
  logic [SIDE_W-1:0]  s1_side_reg;
  logic               s1_pos;

  // The package compare is sized for the default score width; other widths
  // use the same rule written directly.
  if (SCORE_W == SCORE_W_DEF) begin : g_pkg_cmp
    assign s1_pos = is_pos(s1_sum_reg);
  end else begin : g_generic_cmp
    assign s1_pos = !s1_sum_reg[SCORE_W] && (s1_sum_reg != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_sum_reg   <= '0;
      s1_tag_reg   <= '0;
      s1_side_reg  <= '0;
      out_valid    <= 1'b0;
      out_pos      <= 1'b0;
      out_tag      <= '0;
      out_side     <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      s1_sum_reg   <= {score[SCORE_W-1], score} + {bias[SCORE_W-1], bias};
      s1_tag_reg   <= in_tag;
      s1_side_reg  <= in_valid ? in_side : '0;
      out_valid    <= s1_valid_reg;
      out_pos      <= s1_valid_reg & s1_pos;
      if (s1_valid_reg) out_tag <= s1_tag_reg;
      out_side     <= s1_valid_reg ? s1_side_reg : '0;
    end
  end

endmodule

// File: rtl/svm_window_result_gen.sv
// svm_window_result_gen: thresholds bias-adjusted SVM scores and tags each
// result with its slide-window index, sequencing windows over a frame.
// Ports:
//   clk, rst (sync, active-low)
//   frame_start, score_valid, score, bias, err_clr   - inputs
//   o_valid, is_person, sw_id, frame_done            - result stream (2-cycle latency)
//   err_orphan, err_underrun                         - sticky protocol errors
//   person_cnt                                       - only with PERSON_CNT_EN defined:
//                                                      persons in the last completed frame
module svm_window_result_gen
  import svm_window_result_gen_pkg::*;
#(
  parameter int SW_W    = SW_W_DEF,
  parameter int NUM_SW  = NUM_SW_DEF,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] bias,
  input  logic               err_clr,
  output logic               o_valid,
  output logic               is_person,
  output logic [SW_W-1:0]    sw_id,
  output logic               frame_done,
  output logic               err_orphan,
  output logic               err_underrun
`ifdef PERSON_CNT_EN
  ,
  output logic [SW_W:0]      person_cnt
`endif
);

  localparam logic [SW_W-1:0] LAST_ID = SW_W'(NUM_SW - 1);

`ifdef PERSON_CNT_EN
  // Side band: bit 0 = last window of a frame, bit 1 = frame generation.
  localparam int SIDE_W = 2;
`else
  localparam int SIDE_W = 1;
`endif

  state_t            state_reg;
  logic [SW_W-1:0]   cnt_reg;
  logic              abort;
  logic              accept;
  logic              orphan;
  logic              last_in;
  logic [SW_W-1:0]   tag;
  logic [SIDE_W-1:0] side_in;
  logic [SIDE_W-1:0] side_out;

  always_comb begin
    abort   = frame_start && (state_reg == ST_RUN) && (cnt_reg != '0);
    // A score arriving with frame_start always belongs to the new frame.
    accept  = score_valid && (frame_start || (state_reg == ST_RUN));
    orphan  = score_valid && !accept;
    tag     = frame_start ? '0 : cnt_reg;
    last_in = accept && (tag == LAST_ID);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else if (accept) begin
      if (last_in) begin
        state_reg <= ST_DRAIN;
        cnt_reg   <= '0;
      end else begin
        state_reg <= ST_RUN;
        cnt_reg   <= tag + 1'b1;
      end
    end else if (frame_start) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else if ((state_reg == ST_DRAIN) && frame_done) begin
      // The last window is on the outputs this cycle and leaves at this edge.
      state_reg <= ST_IDLE;
    end
  end

  // Set wins over clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_orphan   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      err_orphan   <= orphan | (err_orphan   & ~err_clr);
      err_underrun <= abort  | (err_underrun & ~err_clr);
    end
  end

`ifdef PERSON_CNT_EN
  logic           gen_reg;
  logic           gen_in;
  logic [SW_W:0]  pcnt_reg;

  // Each abort starts a new generation so that results still draining from
  // the aborted frame are not counted against the new one.
  assign gen_in  = gen_reg ^ abort;
  assign side_in = {gen_in, last_in};

  always_ff @(posedge clk) begin
    if (!rst) begin
      gen_reg    <= 1'b0;
      pcnt_reg   <= '0;
      person_cnt <= '0;
    end else begin
      gen_reg <= gen_in;
      if (frame_done) begin
        person_cnt <= pcnt_reg + {{SW_W{1'b0}}, is_person};
        pcnt_reg   <= '0;
      end else if (abort) begin
        pcnt_reg <= '0;
      end else if (is_person && (side_out[1] == gen_reg)) begin
        pcnt_reg <= pcnt_reg + 1'b1;
      end
    end
  end
`else
  assign side_in = last_in;
`endif

  svm_score_pipe #(
    .SCORE_W (SCORE_W),
    .SW_W    (SW_W),
    .SIDE_W  (SIDE_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .score     (score),
    .bias      (bias),
    .in_tag    (tag),
    .in_side   (side_in),
    .out_valid (o_valid),
    .out_pos   (is_person),
    .out_tag   (sw_id),
    .out_side  (side_out)
  );

  // Side band is zero whenever o_valid is low.
  assign frame_done = side_out[0];

endmodule
